gate_checker: RTL and testbench
===============================

Name: gate_checker

Overview:
- Sequential exerciser for the two-input logic gates (AND/OR/NOR/XOR); it sits at the opposite end of a gate from its inputs.
- On request, it drives the gate inputs through all four input vectors and waits a programmable settle time per vector.
- It samples the gate output and compares it against a golden function.
- It reports pass/fail, a mismatch count and a per-vector failure map.

Parameters:
- GATE_OP, 0, expected function: 0=AND, 1=OR, 2=NOR, 3=XOR; any other value is an elaboration $error.
- SETTLE_CYCLES, 2, cycles the inputs are held before sampling; must be >=1, else elaboration $error.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_start  input  1  run request, sampled only in IDLE.
- o_a  output  1  drives the gate's first input.
- o_b  output  1  drives the gate's second input.
- i_c  input  1  gate output under test.
- o_busy  output  1  high in SETTLE and SAMPLE.
- o_done  output  1  one-cycle pulse in DONE.
- o_pass  output  1  1 when the last run had zero mismatches; held until the next start.
- o_err_count  output  3  mismatch count of the last run, 0..4.
- o_fail_vec  output  4  bit v set when vector v={a,b} mismatched (a is MSB).

Behaviour:
- Reset (i_rst_n=0, async, at any time including mid-run): state=IDLE, vector counter=0, settle counter=0. All outputs are 0: o_a, o_b, o_busy, o_done, o_pass, o_err_count, o_fail_vec.
- States: IDLE, SETTLE, SAMPLE, DONE, encoded as a 2-bit enum.
- IDLE:
  - If i_start=1, go to SETTLE with vec=0 and settle counter=0.
  - On the same edge, clear o_pass, o_err_count and o_fail_vec.
  - Otherwise stay in IDLE and hold the last results.
- SETTLE:
  - o_a=vec[1], o_b=vec[0].
  - The counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE:
  - o_a/o_b are still held. Compare i_c with golden(o_a,o_b).
  - On mismatch, set o_fail_vec[vec] and increment o_err_count, both visible next cycle.
  - If vec==3, go to DONE. Otherwise increment vec, clear the settle counter and go to SETTLE.
- DONE:
  - o_done=1 for exactly one cycle; o_pass=(o_err_count==0); o_a=o_b=0.
  - Unconditionally return to IDLE.
- o_a/o_b are 0 in IDLE and DONE; they are registered outputs with no glitching between vectors.
- Latency: with start sampled at edge 0, each vector takes SETTLE_CYCLES+1 cycles, and DONE is in cycle 4*(SETTLE_CYCLES+1)+1. With the default, DONE is in cycle 13.
- i_start is ignored in SETTLE, SAMPLE and DONE; no queuing.
- i_start held high continuously gives back-to-back runs with a period of 4*(SETTLE_CYCLES+1)+2 cycles (14 by default).
- The error counter never wraps: its maximum is 4, which fits in 3 bits.
- An X/Z on i_c in simulation counts as a mismatch (compare with !==).

Optional Feature:
- Macro: GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE. o_err_count=1, exactly one o_fail_vec bit is set, o_pass=0.
- Undefined: all four vectors always run.

Decomposition:
- Package gate_chk_pkg:
  - gate_op_e enum (AND, OR, NOR, XOR).
  - chk_state_e enum.
  - NUM_VECS=4 constant.
  - golden function golden(op,a,b).
- Sub-module gate_model: purely combinational, parameterised by GATE_OP, computing the expected output from o_a/o_b. The checker instantiates it; the bench reuses it as a known-good DUT.

Test Plan:
- GATE_OP=AND, DUT=AND, pulse i_start at cycle 0 -> o_done=1 in cycle 13, o_pass=1, o_err_count=0, o_fail_vec=4'b0000.
- GATE_OP=AND, DUT=OR -> mismatches at vectors 01 and 10: o_fail_vec=4'b0110, o_err_count=2, o_pass=0.
- GATE_OP=NOR, DUT=NOR, SETTLE_CYCLES=1 -> o_done in cycle 9, o_pass=1. Then a second run with DUT i_c stuck at 0 -> o_fail_vec=4'b0001, o_err_count=1.
- Reset asserted in cycle 6 of a run -> all outputs 0 immediately, state IDLE. A restart after release completes with o_pass=1.
- i_start held high, GATE_OP=XOR, DUT=XOR -> o_done pulses in cycles 13, 27, 41, and o_pass stays 1.
- GATE_CHK_STOP_ON_FAIL_EN defined, GATE_OP=AND, DUT i_c stuck at 1 -> mismatch at vec 00 in cycle 3, o_done in cycle 4, o_fail_vec=4'b0001, o_err_count=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types, constants and the golden gate function for the gate checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_NOR = 2'd2,
    OP_XOR = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } chk_state_e;

  localparam int NUM_VECS = 4;
  localparam int VEC_W    = $clog2(NUM_VECS);
  localparam int ERR_W    = $clog2(NUM_VECS + 1);

  function automatic logic golden(gate_op_e op, logic a, logic b);
    logic res;
    res = 1'b0;
    unique case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOR: res = ~(a | b);
      OP_XOR: res = a ^ b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_checker_model.sv
// Combinational reference gate; gives the value the gate under test should produce.
module gate_model
  import gate_chk_pkg::*;
#(
  parameter int GATE_OP = 0
) (
  input  logic a,
  input  logic b,
  output logic c
);

  localparam gate_op_e OP = gate_op_e'(GATE_OP[1:0]);

  assign c = golden(OP, a, b);

endmodule

// File: rtl/gate_checker.sv
// Sequential two-input gate exerciser: walks all input vectors, samples the gate, reports results.
// Optional build macro GATE_CHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for i_start, last results held
// ST_SETTLE | vector driven on o_a/o_b, waiting settle time
// ST_SAMPLE | compare i_c against golden, record mismatch
// ST_DONE   | one-cycle done pulse, o_pass updated
module gate_checker
  import gate_chk_pkg::*;
#(
  parameter int GATE_OP       = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_a,
  output logic             o_b,
  input  logic             i_c,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [NUM_VECS-1:0] o_fail_vec
);

  generate
    if (GATE_OP < 0 || GATE_OP > 3) begin : g_bad_op
      $error("gate_checker: GATE_OP=%0d is not one of 0..3", GATE_OP);
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("gate_checker: SETTLE_CYCLES=%0d must be at least 1", SETTLE_CYCLES);
    end
  endgenerate

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VECS);

  chk_state_e          state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [NUM_VECS-1:0] fail_q, fail_d;
  logic                pass_q, pass_d;
  logic                exp_c;
  logic                mismatch;

  gate_model #(
    .GATE_OP(GATE_OP)
  ) u_model (
    .a(a_q),
    .b(b_q),
    .c(exp_c)
  );

  // X/Z on the gate output must be treated as a failure.
  assign mismatch = (i_c !== exp_c);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = 1'b0;
    b_d     = 1'b0;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end

      ST_SETTLE: begin
        a_d = a_q;
        b_d = b_q;
        if (cnt_q == CNT_TC) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        a_d = a_q;
        b_d = b_q;
        if (mismatch) begin
          fail_d[vec_q] = 1'b1;
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        if (vec_q == LAST_VEC || (STOP_ON_FAIL && mismatch)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          // Load the next vector directly so o_a/o_b change once, cleanly, on the edge.
          state_d = ST_SETTLE;
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_pass      = pass_q;
  assign o_err_count = err_q;
  assign o_fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: scoreboard of expected run results, three checker instances.
`timescale 1ns/1ps
module tb_gate_checker;
  import gate_chk_pkg::*;

  localparam int N     = 3;
  localparam int S_AND = 2;
  localparam int S_NOR = 1;
  localparam int S_XOR = 2;

  typedef struct {
    int         idx;
    int         done_cyc;
    logic       pass;
    logic [2:0] err;
    logic [3:0] fail;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      start = '0;
  logic [N-1:0]      a, b, c, busy, done, pass, ref_c;
  logic [N-1:0][2:0] errc;
  logic [N-1:0][3:0] failv;
  logic [N-1:0]      c_mode = '0;
  logic [3:0]        c_tbl [N];

  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  gate_checker #(.GATE_OP(0), .SETTLE_CYCLES(S_AND)) u_and (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .o_a(a[0]), .o_b(b[0]), .i_c(c[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_err_count(errc[0]), .o_fail_vec(failv[0]));
  gate_checker #(.GATE_OP(2), .SETTLE_CYCLES(S_NOR)) u_nor (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .o_a(a[1]), .o_b(b[1]), .i_c(c[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_err_count(errc[1]), .o_fail_vec(failv[1]));
  gate_checker #(.GATE_OP(3), .SETTLE_CYCLES(S_XOR)) u_xor (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .o_a(a[2]), .o_b(b[2]), .i_c(c[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]), .o_err_count(errc[2]), .o_fail_vec(failv[2]));

  gate_model #(.GATE_OP(0)) u_ref_and (.a(a[0]), .b(b[0]), .c(ref_c[0]));
  gate_model #(.GATE_OP(2)) u_ref_nor (.a(a[1]), .b(b[1]), .c(ref_c[1]));
  gate_model #(.GATE_OP(3)) u_ref_xor (.a(a[2]), .b(b[2]), .c(ref_c[2]));

  // Gate under test: either the known-good model or a bench truth table (bit v = output for {a,b}=v).
  always_comb begin
    c = '0;
    for (int i = 0; i < N; i++) c[i] = c_mode[i] ? c_tbl[i][{a[i], b[i]}] : ref_c[i];
  end

  function automatic logic [3:0] truth(input int op);
    case (op)
      0:       return 4'b1000;
      1:       return 4'b1110;
      2:       return 4'b0001;
      3:       return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t make_exp(input int idx, input int op, input logic [3:0] dut_tbl,
                                    input int s, input int run_ofs);
    exp_t e;
    logic [3:0] f;
    int last;
    f    = truth(op) ^ dut_tbl;
    last = NUM_VECS - 1;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    begin
      bit found;
      found = 1'b0;
      for (int v = 0; v < NUM_VECS; v++) begin
        if (!found && f[v]) begin
          found = 1'b1;
          last  = v;
          f     = 4'(1 << v);
        end
      end
    end
`endif
    e.idx      = idx;
    e.fail     = f;
    e.err      = 3'($countones(f));
    e.pass     = (f == 4'b0000);
    e.done_cyc = run_ofs + (last + 1) * (s + 1) + 1;
    return e;
  endfunction

  task automatic start_pulse(input int idx, output int ref_e);
    @(negedge clk);
    start[idx] = 1'b1;
    ref_e = edge_cnt;
    @(negedge clk);
    start[idx] = 1'b0;
  endtask

  // Waits for o_done on instance idx, pops the expected result and compares; leaves on the cycle after done.
  task automatic wait_done(input int idx, input int ref_e, input int s, input bit chk_trace);
    exp_t e;
    bit seen, trace_bad;
    int rel, v;
    logic [1:0] vv;
    seen = 1'b0;
    trace_bad = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      rel = edge_cnt - ref_e;
      if (done[idx]) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty inst%0d: unexpected done at cycle %0d", idx, rel);
        end else begin
          e = sb.pop_front();
          checks++;
          if (rel !== e.done_cyc) begin
            failures++;
            $display("FAIL done_cycle inst%0d: got %0d expected %0d", idx, rel, e.done_cyc);
          end
          checks++;
          if (pass[idx] !== e.pass) begin
            failures++;
            $display("FAIL pass inst%0d: got %b expected %b", idx, pass[idx], e.pass);
          end
          checks++;
          if (errc[idx] !== e.err) begin
            failures++;
            $display("FAIL err_count inst%0d: got %0d expected %0d", idx, errc[idx], e.err);
          end
          checks++;
          if (failv[idx] !== e.fail) begin
            failures++;
            $display("FAIL fail_vec inst%0d: got %b expected %b", idx, failv[idx], e.fail);
          end
          checks++;
          if ({a[idx], b[idx], busy[idx]} !== 3'b000) begin
            failures++;
            $display("FAIL done_outputs inst%0d: a,b,busy got %b expected 000", idx, {a[idx], b[idx], busy[idx]});
          end
          @(negedge clk);
          checks++;
          if ({done[idx], busy[idx], pass[idx]} !== {2'b00, e.pass}) begin
            failures++;
            $display("FAIL after_done inst%0d: done,busy,pass got %b expected %b",
                     idx, {done[idx], busy[idx], pass[idx]}, {2'b00, e.pass});
          end
        end
      end else begin
        if (chk_trace && rel >= 1 && rel <= NUM_VECS * (s + 1)) begin
          v  = (rel - 1) / (s + 1);
          vv = 2'(v);
          if ({a[idx], b[idx], busy[idx]} !== {vv, 1'b1}) begin
            trace_bad = 1'b1;
            $display("FAIL vec_trace inst%0d cycle %0d: a,b,busy got %b expected %b",
                     idx, rel, {a[idx], b[idx], busy[idx]}, {vv, 1'b1});
          end
        end
        @(negedge clk);
      end
    end
    if (chk_trace) begin
      checks++;
      if (trace_bad) failures++;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout inst%0d: got no done expected done", idx);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic check_idle_zero(input int idx, input string tag);
    checks++;
    if ({a[idx], b[idx], busy[idx], done[idx], pass[idx], errc[idx], failv[idx]} !== 12'h000) begin
      failures++;
      $display("FAIL %s inst%0d: outputs got %b expected all zero", tag, idx,
               {a[idx], b[idx], busy[idx], done[idx], pass[idx], errc[idx], failv[idx]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < N; i++) check_idle_zero(i, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and_pass();
    int r;
    c_mode[0] = 1'b0;
    sb.push_back(make_exp(0, 0, truth(0), S_AND, 0));
    start_pulse(0, r);
    wait_done(0, r, S_AND, 1'b1);
  endtask

  task automatic test_and_vs_or();
    int r;
    c_mode[0] = 1'b1;
    c_tbl[0]  = truth(1);
    sb.push_back(make_exp(0, 0, truth(1), S_AND, 0));
    start_pulse(0, r);
    checks++;
    if ({pass[0], errc[0], failv[0]} !== 8'h00) begin
      failures++;
      $display("FAIL start_clear inst0: pass,err,fail got %b expected 0", {pass[0], errc[0], failv[0]});
    end
    wait_done(0, r, S_AND, 1'b1);
  endtask

  task automatic test_stuck_high();
    int r;
    c_mode[0] = 1'b1;
    c_tbl[0]  = 4'b1111;
    sb.push_back(make_exp(0, 0, 4'b1111, S_AND, 0));
    start_pulse(0, r);
    wait_done(0, r, S_AND, 1'b1);
  endtask

  task automatic test_nor();
    int r;
    c_mode[1] = 1'b0;
    sb.push_back(make_exp(1, 2, truth(2), S_NOR, 0));
    start_pulse(1, r);
    wait_done(1, r, S_NOR, 1'b1);
    c_mode[1] = 1'b1;
    c_tbl[1]  = 4'b0000;
    sb.push_back(make_exp(1, 2, 4'b0000, S_NOR, 0));
    start_pulse(1, r);
    wait_done(1, r, S_NOR, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int r;
    c_mode[0] = 1'b0;
    start_pulse(0, r);
    while (edge_cnt - r < 6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero(0, "mid_run_reset");
    @(negedge clk);
    check_idle_zero(0, "reset_held");
    rst_n = 1'b1;
    sb.push_back(make_exp(0, 0, truth(0), S_AND, 0));
    start_pulse(0, r);
    wait_done(0, r, S_AND, 1'b1);
  endtask

  task automatic test_ignore_start();
    int r;
    c_mode[0] = 1'b0;
    sb.push_back(make_exp(0, 0, truth(0), S_AND, 0));
    start_pulse(0, r);
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, r, S_AND, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL start_not_queued inst0: busy got %b expected 0", busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    int r;
    c_mode[2] = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back(make_exp(2, 3, truth(3), S_XOR, k * (4 * (S_XOR + 1) + 2)));
    @(negedge clk);
    start[2] = 1'b1;
    r = edge_cnt;
    wait_done(2, r, S_XOR, 1'b1);
    wait_done(2, r, S_XOR, 1'b0);
    wait_done(2, r, S_XOR, 1'b0);
    start[2] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop inst2: busy got %b expected 0", busy[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) c_tbl[i] = 4'b0000;
    test_reset();
    test_and_pass();
    test_and_vs_or();
    test_stuck_high();
    test_nor();
    test_reset_mid_run();
    test_ignore_start();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
